// File: rtl/bp_table_ctrl.sv
// Branch prediction table controller: direct-mapped 2-bit counter table with tagged targets,
// 2-entry update queue, and a reset-time clear sweep. Define BP_STATS_EN to build the stat counters.
module bp_table_ctrl #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid_f,
  input  logic [31:0] lookup_pc_f,
  output logic        lookup_ready_f,
  output logic        pred_valid_f,
  output logic        predicted_taken_f,
  output logic [31:0] predicted_target_f,
  input  logic        flush_e,
  input  logic        update_valid_e,
  input  logic [31:0] update_pc_e,
  input  logic        update_taken_e,
  input  logic [31:0] update_target_e,
  input  logic        update_mispredict_e,
  output logic        init_busy,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr;
  logic             run;

  logic             tbl_valid [ENTRIES];
  logic [TAG_W-1:0] tbl_tag   [ENTRIES];
  logic [1:0]       tbl_ctr   [ENTRIES];
  logic [31:0]      tbl_tgt   [ENTRIES];

  upd_t       q [2];
  logic [1:0] q_cnt;
  upd_t       upd_new, hd;
  logic       enq, drain, lk_acc;

  assign run       = (state == ST_RUN);
  assign init_busy = ~run;

  // FSM: sweep every entry once, then serve lookups
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_INIT) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: if (ptr == IDX_W'(ENTRIES - 1)) state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_INIT;
    endcase
  end

  // Slot arbitration: a full queue always drains, otherwise fetch has priority
  assign lookup_ready_f = run & (q_cnt != 2'd2) & ~flush_e;
  assign lk_acc         = lookup_ready_f & lookup_valid_f;
  assign enq            = run & update_valid_e;

  always_comb begin
    drain = 1'b0;
    if (run) begin
      if (q_cnt == 2'd2)                drain = 1'b1;
      else if (lookup_valid_f & ~flush_e) drain = 1'b0;
      else if (q_cnt != 2'd0)           drain = 1'b1;
    end
  end

  assign upd_new = '{pc: update_pc_e, taken: update_taken_e, target: update_target_e};
  assign hd      = q[0];

  // Head is slot 0; a simultaneous enqueue lands behind whatever survives the drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q[0]  <= '0;
      q[1]  <= '0;
      q_cnt <= '0;
    end else begin
      if (drain) q[0] <= q[1];
      if (enq) begin
        if ((q_cnt - {1'b0, drain}) == 2'd0) q[0] <= upd_new;
        else                                 q[1] <= upd_new;
      end
      q_cnt <= q_cnt + {1'b0, enq} - {1'b0, drain};
    end
  end

  // Lookup read path
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit, lk_taken;
  logic [31:0]      lk_tgt;

  assign lk_idx   = lookup_pc_f[IDX_W+1:2];
  assign lk_tag   = lookup_pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_hit   = tbl_valid[lk_idx] & (tbl_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit & tbl_ctr[lk_idx][1];
  assign lk_tgt   = lk_taken ? tbl_tgt[lk_idx] : lookup_pc_f + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_f       <= 1'b0;
      predicted_taken_f  <= 1'b0;
      predicted_target_f <= '0;
    end else begin
      pred_valid_f <= lk_acc;
      if (lk_acc) begin
        predicted_taken_f  <= lk_taken;
        predicted_target_f <= lk_tgt;
      end
    end
  end

  // Single table write port shared by the sweep and queue drains
  logic [IDX_W-1:0] dr_idx, wr_idx;
  logic [TAG_W-1:0] dr_tag, wr_tag;
  logic             dr_hit, wr_en, wr_valid;
  logic [1:0]       dr_ctr, wr_ctr;
  logic [31:0]      wr_tgt;

  assign dr_idx = hd.pc[IDX_W+1:2];
  assign dr_tag = hd.pc[IDX_W+TAG_W+1:IDX_W+2];
  assign dr_hit = tbl_valid[dr_idx] & (tbl_tag[dr_idx] == dr_tag);
  assign dr_ctr = tbl_ctr[dr_idx];

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = ptr;
    wr_valid = 1'b0;
    wr_tag   = '0;
    wr_ctr   = 2'b01;
    wr_tgt   = '0;
    if (!run) begin
      wr_en = 1'b1;
    end else if (drain) begin
      wr_idx   = dr_idx;
      wr_valid = 1'b1;
      wr_tag   = dr_tag;
      if (dr_hit) begin
        wr_en  = 1'b1;
        wr_tgt = hd.taken ? hd.target : tbl_tgt[dr_idx];
        if (hd.taken) wr_ctr = (dr_ctr == 2'b11) ? 2'b11 : dr_ctr + 2'd1;
        else          wr_ctr = (dr_ctr == 2'b00) ? 2'b00 : dr_ctr - 2'd1;
      end else if (hd.taken) begin
        wr_en  = 1'b1;
        wr_ctr = 2'b10;
        wr_tgt = hd.target;
      end
    end
  end

  // Table storage is deliberately unreset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_valid[wr_idx] <= wr_valid;
      tbl_tag[wr_idx]   <= wr_tag;
      tbl_ctr[wr_idx]   <= wr_ctr;
      tbl_tgt[wr_idx]   <= wr_tgt;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (lk_acc) stat_lookups <= stat_lookups + 32'd1;
      if (run & update_valid_e & update_mispredict_e)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_lookups     = '0;
  assign stat_mispredicts = '0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, lookup_pc_f, update_pc_e, update_mispredict_e, hd.pc};

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl: vector table for predict/update behaviour,
// hand sequences for reset sweep, queue backpressure, flush and stats.
module tb_bp_table_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid_f;
  logic [31:0] lookup_pc_f;
  logic        lookup_ready_f;
  logic        pred_valid_f;
  logic        predicted_taken_f;
  logic [31:0] predicted_target_f;
  logic        flush_e;
  logic        update_valid_e;
  logic [31:0] update_pc_e;
  logic        update_taken_e;
  logic [31:0] update_target_e;
  logic        update_mispredict_e;
  logic        init_busy;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  bp_table_ctrl #(.ENTRIES(64), .IDX_W(6), .TAG_W(8)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid_f(lookup_valid_f), .lookup_pc_f(lookup_pc_f), .lookup_ready_f(lookup_ready_f),
    .pred_valid_f(pred_valid_f), .predicted_taken_f(predicted_taken_f),
    .predicted_target_f(predicted_target_f),
    .flush_e(flush_e), .update_valid_e(update_valid_e), .update_pc_e(update_pc_e),
    .update_taken_e(update_taken_e), .update_target_e(update_target_e),
    .update_mispredict_e(update_mispredict_e),
    .init_busy(init_busy), .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          is_upd;
    logic [31:0] pc;
    bit          taken;
    logic [31:0] tgt;
    bit          exp_taken;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add_upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    vt.push_back('{is_upd: 1'b1, pc: pc, taken: t, tgt: tgt, exp_taken: 1'b0, exp_tgt: 32'h0});
  endtask

  task automatic add_lk(input logic [31:0] pc, input bit et, input logic [31:0] etgt);
    vt.push_back('{is_upd: 1'b0, pc: pc, taken: 1'b0, tgt: 32'h0, exp_taken: et, exp_tgt: etgt});
  endtask

  // Called #1 after a rising edge; leaves time #1 after a later rising edge
  task automatic do_lookup(input string name, input logic [31:0] pc, input bit et,
                           input logic [31:0] etgt);
    lookup_valid_f = 1'b1;
    lookup_pc_f    = pc;
    #1 chk({name, ".ready"}, {31'b0, lookup_ready_f}, 32'd1);
    @(posedge clk); #1;
    lookup_valid_f = 1'b0;
    chk({name, ".pvalid"}, {31'b0, pred_valid_f}, 32'd1);
    chk({name, ".taken"}, {31'b0, predicted_taken_f}, {31'b0, et});
    chk({name, ".target"}, predicted_target_f, etgt);
  endtask

  task automatic upd_drain(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                           input bit misp);
    update_valid_e      = 1'b1;
    update_pc_e         = pc;
    update_taken_e      = t;
    update_target_e     = tgt;
    update_mispredict_e = misp;
    @(posedge clk); #1;
    update_valid_e      = 1'b0;
    update_mispredict_e = 1'b0;
    @(posedge clk); #1;
  endtask

  bit          exp_rdy [5] = '{1, 1, 0, 0, 1};
  bit          exp_pv  [5] = '{1, 1, 0, 0, 1};
  logic [31:0] bp_pc   [3] = '{32'h2000, 32'h2004, 32'h2008};
  logic [31:0] bp_tgt  [3] = '{32'h5000, 32'h5004, 32'h5008};

  initial begin
    rst = 1'b1;
    lookup_valid_f = 0; lookup_pc_f = 0; flush_e = 0;
    update_valid_e = 0; update_pc_e = 0; update_taken_e = 0; update_target_e = 0;
    update_mispredict_e = 0;

    // Vector table: counter walk, saturation, tag replacement, pc+4 wrap
    add_lk (32'h1000, 0, 32'h1004);
    add_upd(32'h1000, 1, 32'h2000);
    add_lk (32'h1000, 1, 32'h2000);
    add_upd(32'h1000, 1, 32'h2000);
    add_lk (32'h1000, 1, 32'h2000);
    add_upd(32'h1000, 0, 32'h0);
    add_lk (32'h1000, 1, 32'h2000);
    add_upd(32'h1000, 0, 32'h0);
    add_lk (32'h1000, 0, 32'h1004);
    add_upd(32'h1000, 0, 32'h0);
    add_upd(32'h1000, 0, 32'h0);
    add_upd(32'h1000, 1, 32'h3000);
    add_lk (32'h1000, 0, 32'h1004);
    add_upd(32'h1000, 1, 32'h3000);
    add_lk (32'h1000, 1, 32'h3000);
    add_lk (32'h1100, 0, 32'h1104);
    add_upd(32'h1100, 0, 32'h0);
    add_lk (32'h1000, 1, 32'h3000);
    add_upd(32'h1100, 1, 32'h4000);
    add_lk (32'h1100, 1, 32'h4000);
    add_lk (32'h1000, 0, 32'h1004);
    add_lk (32'hFFFF_FFFC, 0, 32'h0000_0000);

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", {31'b0, init_busy}, 32'd1);
    chk("rst.ready", {31'b0, lookup_ready_f}, 32'd0);
    chk("rst.pvalid", {31'b0, pred_valid_f}, 32'd0);
    chk("rst.taken", {31'b0, predicted_taken_f}, 32'd0);
    chk("rst.target", predicted_target_f, 32'd0);
    chk("rst.stat_lk", stat_lookups, 32'd0);
    chk("rst.stat_mp", stat_mispredicts, 32'd0);
    rst = 1'b0;

    for (int c = 0; c < 64; c++) begin
      chk($sformatf("init%0d.ready", c), {31'b0, lookup_ready_f}, 32'd0);
      chk($sformatf("init%0d.busy", c), {31'b0, init_busy}, 32'd1);
      @(posedge clk); #1;
    end
    chk("run.ready", {31'b0, lookup_ready_f}, 32'd1);
    chk("run.busy", {31'b0, init_busy}, 32'd0);

    foreach (vt[i]) begin
      if (vt[i].is_upd) begin
        upd_drain(vt[i].pc, vt[i].taken, vt[i].tgt, 1'b0);
        chk($sformatf("vec%0d.idle_pv", i), {31'b0, pred_valid_f}, 32'd0);
      end else begin
        do_lookup($sformatf("vec%0d", i), vt[i].pc, vt[i].exp_taken, vt[i].exp_tgt);
      end
    end

    // Continuous lookups with three back-to-back updates
    lookup_valid_f = 1'b1;
    lookup_pc_f    = 32'h0040;
    for (int k = 0; k < 5; k++) begin
      update_valid_e  = (k < 3);
      update_pc_e     = (k < 3) ? bp_pc[k] : 32'h0;
      update_taken_e  = 1'b1;
      update_target_e = (k < 3) ? bp_tgt[k] : 32'h0;
      #1 chk($sformatf("bp%0d.ready", k), {31'b0, lookup_ready_f}, {31'b0, exp_rdy[k]});
      @(posedge clk); #1;
      chk($sformatf("bp%0d.pvalid", k), {31'b0, pred_valid_f}, {31'b0, exp_pv[k]});
    end
    lookup_valid_f = 1'b0;
    update_valid_e = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      do_lookup($sformatf("bp_verify%0d", k), bp_pc[k], 1'b1, bp_tgt[k]);

    // Flush blocks acceptance but not an already-registered prediction
    lookup_valid_f = 1'b1;
    lookup_pc_f    = 32'h2000;
    flush_e        = 1'b1;
    #1 chk("flush.ready", {31'b0, lookup_ready_f}, 32'd0);
    @(posedge clk); #1;
    chk("flush.pvalid", {31'b0, pred_valid_f}, 32'd0);
    flush_e = 1'b0;
    #1 chk("flush2.ready", {31'b0, lookup_ready_f}, 32'd1);
    @(posedge clk); #1;
    flush_e = 1'b1;
    #1 chk("flush2.pvalid_held", {31'b0, pred_valid_f}, 32'd1);
    chk("flush2.target", predicted_target_f, 32'h5000);
    chk("flush2.ready_blk", {31'b0, lookup_ready_f}, 32'd0);
    @(posedge clk); #1;
    chk("flush2.pvalid_after", {31'b0, pred_valid_f}, 32'd0);
    lookup_valid_f = 1'b0;
    flush_e        = 1'b0;

    // Mid-operation reset with an update still queued
    update_valid_e  = 1'b1;
    update_pc_e     = 32'h3000;
    update_taken_e  = 1'b1;
    update_target_e = 32'h6000;
    @(posedge clk); #1;
    update_valid_e = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst.busy", {31'b0, init_busy}, 32'd1);
    chk("mrst.ready", {31'b0, lookup_ready_f}, 32'd0);
    chk("mrst.pvalid", {31'b0, pred_valid_f}, 32'd0);
    chk("mrst.target", predicted_target_f, 32'd0);
    chk("mrst.stat_lk", stat_lookups, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // Updates during INIT must be ignored (including stats)
    update_valid_e      = 1'b1;
    update_mispredict_e = 1'b1;
    repeat (63) @(posedge clk);
    #1 chk("minit.busy", {31'b0, init_busy}, 32'd1);
    chk("minit.ready", {31'b0, lookup_ready_f}, 32'd0);
    @(posedge clk); #1;
    update_valid_e      = 1'b0;
    update_mispredict_e = 1'b0;
    chk("mrun.ready", {31'b0, lookup_ready_f}, 32'd1);

    do_lookup("mrun.q_cleared", 32'h3000, 1'b0, 32'h3004);
    do_lookup("mrun.swept1", 32'h1100, 1'b0, 32'h1104);
    do_lookup("mrun.swept2", 32'h2000, 1'b0, 32'h2004);
    upd_drain(32'h3000, 1'b0, 32'h0, 1'b1);
    upd_drain(32'h3004, 1'b0, 32'h0, 1'b1);
    do_lookup("mrun.lk4", 32'h2004, 1'b0, 32'h2008);
    do_lookup("mrun.lk5", 32'h2008, 1'b0, 32'h200C);
`ifdef BP_STATS_EN
    chk("stat.lookups", stat_lookups, 32'd5);
    chk("stat.mispredicts", stat_mispredicts, 32'd2);
`else
    chk("stat.lookups", stat_lookups, 32'd0);
    chk("stat.mispredicts", stat_mispredicts, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
